// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: multi-cycle fetch/decode/execute controller for the
// accumulator machine. It drives register load strobes, mux selects, the ALU
// opcode and the memory request lines, with a memory ready handshake and
// timeout, conditional jump, halt/run control and a retired-instruction counter.
//
// Optional feature macro: ACC_SEQ_ILLEGAL_TRAP_EN
//   defined   : undefined opcodes (A-E) trap to ERROR without retiring
//   undefined : undefined opcodes execute as NOP
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   run                 leaves IDLE/HALTED when high
//   ir                  current IR contents; opcode is the top OPC_W bits
//   acc_zero            ACC == 0, used by JZ
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_we     memory request and direction (1 = write)
//   mar_load, mar_sel   MAR load; source 0 = PC, 1 = ir address field
//   mbr_load, mbr_sel   MBR load; source 0 = memory data, 1 = ACC
//   ir_load             load IR from MBR
//   pc_inc, pc_load     PC increment / load from ir address field
//   acc_load, acc_sel   ACC load; source 0 = ALU result, 1 = MBR
//   alu_op              ALU opcode, valid in EXEC_WB, zero elsewhere
//   halted, error       state is HALTED / ERROR
//   retired             completed-instruction count, wraps
module acc_cpu_sequencer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  input  logic              acc_zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mar_load,
  output logic              mar_sel,
  output logic              mbr_load,
  output logic              mbr_sel,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              acc_load,
  output logic              acc_sel,
  output logic [3:0]        alu_op,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  retired
);

  // Wait counter holds 0 .. TIMEOUT_CYC-1 while a memory state is stalled
  localparam int unsigned TO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  typedef enum logic [3:0] {
    IDLE, FETCH_A, FETCH_M, FETCH_IR, DECODE,
    EXEC_A, EXEC_M, EXEC_WB, HALTED, ERROR
  } state_t;

  state_t          state;
  logic [TO_W-1:0] tcnt;
  logic [OPC_W-1:0] opc;

  logic is_nop, is_load, is_store, is_alu, is_jump, is_jz, is_halt;
  logic jump_taken, timeout_hit;

  // Address field is consumed by the datapath, not by the sequencer
  logic unused_addr;
  assign unused_addr = ^ir[DATA_W-OPC_W-1:0];

  assign opc      = ir[DATA_W-1 -: OPC_W];
  assign is_nop   = (opc == OPC_W'(4'h0));
  assign is_load  = (opc == OPC_W'(4'h1));
  assign is_store = (opc == OPC_W'(4'h2));
  assign is_alu   = (opc >= OPC_W'(4'h3)) && (opc <= OPC_W'(4'h7));
  assign is_jump  = (opc == OPC_W'(4'h8));
  assign is_jz    = (opc == OPC_W'(4'h9));
  assign is_halt  = (opc == OPC_W'(4'hF));

  assign jump_taken  = is_jump || (is_jz && acc_zero);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (tcnt == TO_W'(TO_LAST));

  // State, wait counter and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE, HALTED: if (run) state <= FETCH_A;
        FETCH_A: begin
          state <= FETCH_M;
          tcnt  <= '0;
        end
        FETCH_M: begin
          if (mem_ready)        state <= FETCH_IR;
          else if (timeout_hit) state <= ERROR;
          else                  tcnt  <= tcnt + TO_W'(1);
        end
        FETCH_IR: state <= DECODE;
        DECODE: begin
          if (is_halt) begin
            state   <= HALTED;
            retired <= retired + CNT_W'(1);
          end else if (is_load || is_store || is_alu) begin
            state <= EXEC_A;
          end else if (is_nop || is_jump || is_jz) begin
            state   <= FETCH_A;
            retired <= retired + CNT_W'(1);
          end else begin
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
            state <= ERROR;
`else
            state   <= FETCH_A;
            retired <= retired + CNT_W'(1);
`endif
          end
        end
        EXEC_A: begin
          state <= EXEC_M;
          tcnt  <= '0;
        end
        EXEC_M: begin
          if (mem_ready) begin
            if (is_store) begin
              state   <= FETCH_A;
              retired <= retired + CNT_W'(1);
            end else begin
              state <= EXEC_WB;
            end
          end else if (timeout_hit) begin
            state <= ERROR;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        EXEC_WB: begin
          state   <= FETCH_A;
          retired <= retired + CNT_W'(1);
        end
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

  // Strobes decoded from the state register; MBR capture follows mem_ready
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    mbr_load = 1'b0;
    mbr_sel  = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    acc_sel  = 1'b0;
    alu_op   = 4'b0000;
    halted   = (state == HALTED);
    error    = (state == ERROR);
    case (state)
      FETCH_A: mar_load = 1'b1;
      FETCH_M: begin
        mem_req  = 1'b1;
        mbr_load = mem_ready;
      end
      FETCH_IR: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      DECODE: pc_load = jump_taken;
      EXEC_A: begin
        mar_load = 1'b1;
        mar_sel  = 1'b1;
        mbr_load = is_store;
        mbr_sel  = is_store;
      end
      EXEC_M: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mbr_load = mem_ready && !is_store;
      end
      EXEC_WB: begin
        acc_load = 1'b1;
        acc_sel  = is_load;
        case (opc)
          OPC_W'(4'h4): alu_op = 4'b0001;
          OPC_W'(4'h5): alu_op = 4'b1000;
          OPC_W'(4'h6): alu_op = 4'b1001;
          OPC_W'(4'h7): alu_op = 4'b1010;
          default:      alu_op = 4'b0000;
        endcase
      end
      default: ;
    endcase
  end

endmodule
